// File: rtl/fcl_rbus_pkg.sv
// fcl_rbus_pkg: shared RBus widths, arbiter FSM encoding and timeout-counter sizing.
package fcl_rbus_pkg;
   localparam int RBUS_AW = 16;
   localparam int RBUS_DW = 16;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} rbus_state_t;
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles);
   endfunction
endpackage

// File: rtl/fcl_rbus_req_latch.sv
// fcl_rbus_req_latch: one master's pending request; write wins over read, strobes while full flag overrun.
module fcl_rbus_req_latch import fcl_rbus_pkg::*; #(
   parameter int AW = RBUS_AW,
   parameter int DW = RBUS_DW
) (
   input  logic          sys_clk_buf,
   input  logic          sys_reset,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_data,
   input  logic          rd,
   input  logic          wr,
   input  logic          clear,
   output logic          valid,
   output logic          dir,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data,
   output logic          overrun
);
   logic strobe;
   assign strobe  = rd | wr;
   assign overrun = strobe & valid;
   always_ff @(posedge sys_clk_buf or posedge sys_reset)
      if (sys_reset) begin
         valid <= 1'b0;
         dir   <= 1'b0;
         addr  <= '0;
         data  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (strobe && !valid) begin
         valid <= 1'b1;
         dir   <= wr;
         addr  <= req_addr;
         data  <= req_data;
      end
endmodule

// File: rtl/fcl_rbus_arbiter.sv
// fcl_rbus_arbiter: round-robin two-master RBus arbiter with one outstanding
// transaction on the shared bus and a slave response timeout.
module fcl_rbus_arbiter import fcl_rbus_pkg::*; #(
   parameter int RBUS_ADDR_WIDTH = RBUS_AW,
   parameter int RBUS_DATA_WIDTH = RBUS_DW,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic                       sys_clk_buf,
   input  logic                       sys_reset,
   input  logic [RBUS_ADDR_WIDTH-1:0] m0_addr_in,
   input  logic [RBUS_DATA_WIDTH-1:0] m0_data_in,
   input  logic                       m0_read_in,
   input  logic                       m0_write_in,
   output logic [RBUS_DATA_WIDTH-1:0] m0_data_out,
   output logic                       m0_ack_out,
   output logic                       m0_timeout_out,
   input  logic [RBUS_ADDR_WIDTH-1:0] m1_addr_in,
   input  logic [RBUS_DATA_WIDTH-1:0] m1_data_in,
   input  logic                       m1_read_in,
   input  logic                       m1_write_in,
   output logic [RBUS_DATA_WIDTH-1:0] m1_data_out,
   output logic                       m1_ack_out,
   output logic                       m1_timeout_out,
   output logic [RBUS_ADDR_WIDTH-1:0] bus_addr_out,
   output logic [RBUS_DATA_WIDTH-1:0] bus_data_out,
   output logic                       bus_read_out,
   output logic                       bus_write_out,
   input  logic [RBUS_DATA_WIDTH-1:0] bus_data_in,
   input  logic                       bus_ack_in,
   output logic                       busy_out,
   output logic                       owner_out,
   output logic                       overrun_out
);
   localparam int CW = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   rbus_state_t state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [1:0] valid, dir, clear, ovr;
   logic [RBUS_ADDR_WIDTH-1:0] addr0, addr1, addr_next;
   logic [RBUS_DATA_WIDTH-1:0] data0, data1, wdata_next, rdata_next;
   logic pref, pref_next, grant, owner_next, rd_next, wr_next, ack_next, to_next;

   fcl_rbus_req_latch #(.AW(RBUS_ADDR_WIDTH), .DW(RBUS_DATA_WIDTH)) u_req0 (
      .sys_clk_buf(sys_clk_buf), .sys_reset(sys_reset), .req_addr(m0_addr_in), .req_data(m0_data_in),
      .rd(m0_read_in), .wr(m0_write_in), .clear(clear[0]), .valid(valid[0]), .dir(dir[0]),
      .addr(addr0), .data(data0), .overrun(ovr[0]));
   fcl_rbus_req_latch #(.AW(RBUS_ADDR_WIDTH), .DW(RBUS_DATA_WIDTH)) u_req1 (
      .sys_clk_buf(sys_clk_buf), .sys_reset(sys_reset), .req_addr(m1_addr_in), .req_data(m1_data_in),
      .rd(m1_read_in), .wr(m1_write_in), .clear(clear[1]), .valid(valid[1]), .dir(dir[1]),
      .addr(addr1), .data(data1), .overrun(ovr[1]));

   // m1 wins only when m0 is absent or the preference bit points at m1
   assign grant = valid[1] & (~valid[0] | pref);

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      pref_next  = pref;
      owner_next = owner_out;
      addr_next  = bus_addr_out;
      wdata_next = bus_data_out;
      rd_next    = 1'b0;
      wr_next    = 1'b0;
      ack_next   = 1'b0;
      to_next    = 1'b0;
      rdata_next = '0;
      clear      = 2'b00;
      case (state)
         IDLE: if (|valid) begin
            state_next = ISSUE;
            owner_next = grant;
            pref_next  = ~grant;
            addr_next  = grant ? addr1 : addr0;
            wdata_next = grant ? data1 : data0;
            wr_next    = grant ? dir[1] : dir[0];
            rd_next    = ~wr_next;
         end
         ISSUE: begin
            state_next = WAIT;
            cnt_next   = '0;
         end
         WAIT: if (bus_ack_in) begin
            state_next = RESP;
            ack_next   = 1'b1;
            rdata_next = bus_data_in;
         end else if (cnt == CNT_LAST) begin
            state_next = RESP;
            ack_next   = 1'b1;
            to_next    = 1'b1;
         end else begin
            cnt_next = cnt + 1'b1;
         end
         RESP: begin
            state_next = IDLE;
            clear      = owner_out ? 2'b10 : 2'b01;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_buf or posedge sys_reset)
      if (sys_reset) state <= IDLE;
      else state <= state_next;

   always_ff @(posedge sys_clk_buf or posedge sys_reset)
      if (sys_reset) begin
         cnt            <= '0;
         pref           <= 1'b0;
         owner_out      <= 1'b0;
         bus_addr_out   <= '0;
         bus_data_out   <= '0;
         bus_read_out   <= 1'b0;
         bus_write_out  <= 1'b0;
         m0_ack_out     <= 1'b0;
         m1_ack_out     <= 1'b0;
         m0_timeout_out <= 1'b0;
         m1_timeout_out <= 1'b0;
         m0_data_out    <= '0;
         m1_data_out    <= '0;
         busy_out       <= 1'b0;
         overrun_out    <= 1'b0;
      end else begin
         cnt            <= cnt_next;
         pref           <= pref_next;
         owner_out      <= owner_next;
         bus_addr_out   <= addr_next;
         bus_data_out   <= wdata_next;
         bus_read_out   <= rd_next;
         bus_write_out  <= wr_next;
         m0_ack_out     <= ack_next & ~owner_out;
         m1_ack_out     <= ack_next & owner_out;
         m0_timeout_out <= to_next & ~owner_out;
         m1_timeout_out <= to_next & owner_out;
         m0_data_out    <= owner_out ? '0 : rdata_next;
         m1_data_out    <= owner_out ? rdata_next : '0;
         busy_out       <= state_next != IDLE;
         overrun_out    <= overrun_out | (|ovr);
      end
endmodule
